// File: rtl/vend_pkg.sv
// Shared types and constants for the v_dispense payout controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VEND     = 3'd1,
    ST_COIN_REQ = 3'd2,
    ST_COIN_REL = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } vend_state_e;

  localparam logic [1:0] DRINK_NONE = 2'd0;
  localparam logic [1:0] DRINK_A    = 2'd1;
  localparam logic [1:0] DRINK_B    = 2'd2;
  localparam logic [1:0] DRINK_C    = 2'd3;

  localparam int CD_CHG_MSB = 4;
  localparam int CD_CHG_LSB = 2;
  localparam int CD_DRK_MSB = 1;
  localparam int CD_DRK_LSB = 0;

  function automatic logic [2:0] drink_onehot(input logic [1:0] code);
    logic [2:0] oh;
    case (code)
      DRINK_A: oh = 3'b001;
      DRINK_B: oh = 3'b010;
      DRINK_C: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// 10-bit loadable down-counter shared by the motor run time and the hopper timeout.
module vend_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] value,
  output logic       expired
);

  logic [9:0] count_r;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 10'd0;
    end else if (load) begin
      count_r <= value;
    end else if (count_r != 10'd0) begin
      count_r <= count_r - 10'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry on the last counted cycle so a load of N spans exactly N cycles.
  assign expired = (count_r <= 10'd1);

endmodule

// File: rtl/v_dispense.sv
// Vending payout controller: drink motor then coin-by-coin hopper handshake.
// Optional hopper ack timeout enabled by defining VEND_HOPPER_TIMEOUT_EN.
module v_dispense
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cd,
  input  logic       coin_ack,
  output logic [2:0] motor,
  output logic       coin_req,
  output logic       busy,
  output logic       done,
  output logic [2:0] change_left,
  output logic       ovf,
  output logic       fault
);

  localparam logic [9:0] MOTOR_LOAD   = 10'(MOTOR_CYCLES);
  localparam logic [9:0] TIMEOUT_LOAD = 10'(TIMEOUT_CYCLES);

  vend_state_e state_r, state_nx;
  logic [4:0]  cd_r;
  logic [1:0]  drink_r, drink_nx;
  logic [2:0]  chg_r, chg_nx;
  logic        pend_v_r, pend_v_nx;
  logic [4:0]  pend_cd_r, pend_cd_nx;
  logic        ovf_r, ovf_nx;
  logic        fault_r, fault_nx;
  logic [2:0]  motor_r;
  logic        coin_req_r, busy_r, done_r;

  logic        req_s, start_s, consume_s, store_s;
  logic [4:0]  start_cd_s;
  logic        tload_s, texp_s;
  logic [9:0]  tval_s;

  vend_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tload_s),
    .value   (tval_s),
    .expired (texp_s)
  );

  // Next-state, request dispatch and pending-slot bookkeeping.
  always_comb begin
    state_nx   = state_r;
    drink_nx   = drink_r;
    chg_nx     = chg_r;
    pend_v_nx  = pend_v_r;
    pend_cd_nx = pend_cd_r;
    ovf_nx     = ovf_r;
    fault_nx   = fault_r;
    tload_s    = 1'b0;
    tval_s     = MOTOR_LOAD;
    start_s    = 1'b0;
    start_cd_s = 5'd0;
    req_s      = (cd_r != 5'd0);

    case (state_r)
      ST_IDLE: begin
        if (pend_v_r) begin
          start_s    = 1'b1;
          start_cd_s = pend_cd_r;
        end else if (req_s) begin
          start_s    = 1'b1;
          start_cd_s = cd_r;
        end else begin
          start_s    = 1'b0;
        end
      end
      ST_VEND: begin
        if (texp_s) begin
          if (chg_r != 3'd0) begin
            state_nx = ST_COIN_REQ;
            tload_s  = 1'b1;
            tval_s   = TIMEOUT_LOAD;
          end else begin
            state_nx = ST_DONE;
          end
        end else begin
          state_nx = ST_VEND;
        end
      end
      ST_COIN_REQ: begin
        if (coin_ack) begin
          state_nx = ST_COIN_REL;
          chg_nx   = chg_r - 3'd1;
          tload_s  = 1'b1;
          tval_s   = TIMEOUT_LOAD;
`ifdef VEND_HOPPER_TIMEOUT_EN
        end else if (texp_s) begin
          state_nx = ST_FAULT;
          fault_nx = 1'b1;
`endif
        end else begin
          state_nx = ST_COIN_REQ;
        end
      end
      ST_COIN_REL: begin
        if (!coin_ack) begin
          if (chg_r != 3'd0) begin
            state_nx = ST_COIN_REQ;
            tload_s  = 1'b1;
            tval_s   = TIMEOUT_LOAD;
          end else begin
            state_nx = ST_DONE;
          end
`ifdef VEND_HOPPER_TIMEOUT_EN
        end else if (texp_s) begin
          state_nx = ST_FAULT;
          fault_nx = 1'b1;
`endif
        end else begin
          state_nx = ST_COIN_REL;
        end
      end
      ST_DONE: begin
        if (pend_v_r) begin
          start_s    = 1'b1;
          start_cd_s = pend_cd_r;
        end else begin
          state_nx   = ST_IDLE;
        end
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_IDLE;
    endcase

    if (start_s) begin
      drink_nx = start_cd_s[CD_DRK_MSB:CD_DRK_LSB];
      chg_nx   = start_cd_s[CD_CHG_MSB:CD_CHG_LSB];
      tload_s  = 1'b1;
      if (start_cd_s[CD_DRK_MSB:CD_DRK_LSB] != DRINK_NONE) begin
        state_nx = ST_VEND;
        tval_s   = MOTOR_LOAD;
      end else begin
        state_nx = ST_COIN_REQ;
        tval_s   = TIMEOUT_LOAD;
      end
    end else begin
      drink_nx = drink_nx;
    end

    // A slot freed this cycle can take the new arrival without overflowing.
    consume_s = start_s && pend_v_r;
    store_s   = req_s && (state_r != ST_FAULT) && !(state_r == ST_IDLE && !pend_v_r);
    if (store_s) begin
      if (pend_v_r && !consume_s) begin
        ovf_nx = 1'b1;
      end else begin
        pend_v_nx  = 1'b1;
        pend_cd_nx = cd_r;
      end
    end else if (consume_s) begin
      pend_v_nx = 1'b0;
    end else begin
      pend_v_nx = pend_v_r;
    end
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cd_r       <= 5'd0;
      drink_r    <= DRINK_NONE;
      chg_r      <= 3'd0;
      pend_v_r   <= 1'b0;
      pend_cd_r  <= 5'd0;
      ovf_r      <= 1'b0;
      fault_r    <= 1'b0;
      motor_r    <= 3'b000;
      coin_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cd_r       <= cd;
      drink_r    <= drink_nx;
      chg_r      <= chg_nx;
      pend_v_r   <= pend_v_nx;
      pend_cd_r  <= pend_cd_nx;
      ovf_r      <= ovf_nx;
      fault_r    <= fault_nx;
      motor_r    <= (state_nx == ST_VEND) ? drink_onehot(drink_nx) : 3'b000;
      coin_req_r <= (state_nx == ST_COIN_REQ);
      busy_r     <= (state_nx != ST_IDLE) || pend_v_nx;
      done_r     <= (state_nx == ST_DONE);
    end
  end

  assign motor       = motor_r;
  assign coin_req    = coin_req_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign change_left = chg_r;
  assign ovf         = ovf_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_v_dispense.sv
// Self-checking bench for v_dispense with a behavioural hopper and transaction model.
module tb_v_dispense;

  localparam int M  = 16;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] cd;
  logic       coin_ack;
  logic [2:0] motor;
  logic       coin_req, busy, done, ovf, fault;
  logic [2:0] change_left;

  int total = 0;
  int bad   = 0;
  int hop_wait = 0;

  v_dispense #(.MOTOR_CYCLES(M), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cd(cd), .coin_ack(coin_ack),
    .motor(motor), .coin_req(coin_req), .busy(busy), .done(done),
    .change_left(change_left), .ovf(ovf), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hopper raises ack dly cycles after seeing a request, drops it once the request falls.
  task automatic hopper_step(input int dly);
    if (coin_req && !coin_ack) begin
      if (hop_wait >= dly) begin
        coin_ack = 1'b1;
        hop_wait = 0;
      end else begin
        hop_wait++;
      end
    end else if (!coin_req && coin_ack) begin
      coin_ack = 1'b0;
    end
  endtask

  // One request from idle; expectations come from the drink/change/hopper-delay rules.
  task automatic run_req(input logic [4:0] c, input int dly, input string tag);
    int drk, chg, exp_motor, exp_done, budget;
    int first_act, motor_cnt, motor_bad, coins, both, done_cnt, done_cyc;
    int busy_gap, chg_bad, remaining, busy_after;
    logic prev_req;
    drk = int'(c[1:0]);
    chg = int'(c[4:2]);
    exp_motor = (drk == 0) ? 0 : (1 << (drk - 1));
    exp_done  = ((drk != 0) ? M + 2 : 2) + chg * (dly + 2);
    budget    = exp_done + 10;
    first_act = -1; motor_cnt = 0; motor_bad = 0; coins = 0; both = 0;
    done_cnt = 0; done_cyc = -1; busy_gap = 0; chg_bad = 0; remaining = chg;
    busy_after = -1; prev_req = 1'b0;
    hop_wait = 0; coin_ack = 1'b0;
    @(negedge clk); cd = c;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cd = 5'd0;
      if ((motor != 3'd0 || coin_req) && first_act < 0) first_act = cyc;
      if (motor != 3'd0) begin
        motor_cnt++;
        if (int'(motor) != exp_motor) motor_bad++;
      end
      if (coin_req && !prev_req) begin
        coins++;
        if (int'(change_left) != remaining) chg_bad++;
        remaining--;
      end
      prev_req = coin_req;
      if (motor != 3'd0 && coin_req) both++;
      if (first_act > 0 && done_cyc < 0 && !busy) busy_gap++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (change_left != 3'd0) chg_bad++;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) busy_after = int'(busy);
      hopper_step(dly);
    end
    check({tag, ":latency"},    first_act, 2);
    check({tag, ":motor_cyc"},  motor_cnt, (drk != 0) ? M : 0);
    check({tag, ":motor_val"},  motor_bad, 0);
    check({tag, ":coins"},      coins, chg);
    check({tag, ":overlap"},    both, 0);
    check({tag, ":done_cnt"},   done_cnt, 1);
    check({tag, ":done_cyc"},   done_cyc, exp_done);
    check({tag, ":chg_left"},   chg_bad, 0);
    check({tag, ":busy_gap"},   busy_gap, 0);
    check({tag, ":busy_after"}, busy_after, 0);
  endtask

  initial begin
    int d1, d2, first_b, cnt_a, cnt_b, cnt_c, busy_low, coins_after, motor_after;
    logic [4:0] rc;
    reset = 1'b1; cd = 5'd0; coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:motor",  int'(motor), 0);
    check("rst:outs",   int'({coin_req, busy, done, ovf, fault}), 0);
    check("rst:chg",    int'(change_left), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_req(5'b00011, 0, "drinkC");
    run_req(5'b01010, 3, "drinkB_chg2");
    run_req(5'b11100, 1, "cancel7");

    for (int i = 0; i < 10; i++) begin
      rc = 5'($urandom_range(1, 31));
      run_req(rc, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

`ifdef VEND_HOPPER_TIMEOUT_EN
    begin
      int req_cyc, flt_cyc;
      req_cyc = -1; flt_cyc = -1; coin_ack = 1'b0;
      @(negedge clk); cd = 5'b00100;
      for (int cyc = 1; cyc <= TO + 40; cyc++) begin
        @(negedge clk);
        if (cyc == 1) cd = 5'd0;
        if (coin_req && req_cyc < 0) req_cyc = cyc;
        if (fault && flt_cyc < 0) flt_cyc = cyc;
      end
      check("to:delay", flt_cyc - req_cyc, TO);
      check("to:req_low", int'(coin_req), 0);
      check("to:busy", int'(busy), 1);
      cd = 5'b00011;
      @(negedge clk); cd = 5'd0;
      repeat (3) @(negedge clk);
      check("to:motor_ign", int'(motor), 0);
      check("to:ovf", int'(ovf), 0);
      check("to:fault_hold", int'(fault), 1);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
    end
`endif

    // Three back-to-back requests: run, queue, drop.
    d1 = -1; d2 = -1; first_b = -1; cnt_a = 0; cnt_b = 0; cnt_c = 0; busy_low = 0;
    @(negedge clk); cd = 5'b00001;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cd = 5'b00010;
      else if (cyc == 2) cd = 5'b00011;
      else cd = 5'd0;
      if (motor == 3'b001) cnt_a++;
      if (motor == 3'b010) begin cnt_b++; if (first_b < 0) first_b = cyc; end
      if (motor == 3'b100) cnt_c++;
      if (done) begin
        if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
      end
      if (cyc >= 2 && cyc <= 2 * M + 3 && !busy) busy_low++;
    end
    check("b2b:motorA", cnt_a, M);
    check("b2b:motorB", cnt_b, M);
    check("b2b:motorC", cnt_c, 0);
    check("b2b:done1",  d1, M + 2);
    check("b2b:done2",  d2, 2 * M + 3);
    check("b2b:no_gap", first_b, d1 + 1);
    check("b2b:busy",   busy_low, 0);
    check("b2b:ovf",    int'(ovf), 1);

    // Asynchronous reset in the middle of the motor phase.
    @(negedge clk); cd = 5'b01001;
    @(negedge clk); cd = 5'd0;
    repeat (5) @(negedge clk);
    check("rv:motor_on", int'(motor), 1);
    #2 reset = 1'b1;
    #1;
    check("rv:motor_off", int'(motor), 0);
    check("rv:busy_off",  int'(busy), 0);
    @(negedge clk); reset = 1'b0;
    coins_after = 0; motor_after = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (coin_req) coins_after++;
      if (motor != 3'd0) motor_after++;
    end
    check("rv:no_coins", coins_after, 0);
    check("rv:no_motor", motor_after, 0);
    check("rv:ovf",      int'(ovf), 0);
    check("rv:fault",    int'(fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
